// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - FSM state encodings and index sizing shared by the chunked serial adder
package adder_pkg;

   // 2-bit state encodings
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_RUN  = RUN,
      ST_DONE = DONE
   } state_t;

   // Chunk index width: ceil(log2(nchunk)), never below one bit
   function automatic int idx_bits(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// rtl/chunked_serial_adder_if.sv - operand/result handshake bundle for the chunked serial adder
interface chunked_serial_adder_if #(
   parameter int WIDTH = 16
);

   // operand side
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;

   // result side
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;
   logic             busy;

   // producer of operands and consumer of results
   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf, busy
   );

   // the adder itself
   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, sum, c_out, ovf, busy
   );

endinterface

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational CHUNK-bit adder with carry out and carry into its top bit
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_in,
   output logic [CHUNK-1:0] sum,
   output logic             c_out,
   output logic             c_msb
);

   logic [CHUNK:0] full;

   assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};
   assign sum   = full[CHUNK-1:0];
   assign c_out = full[CHUNK];

   // The top sum bit is a ^ b ^ carry-in, so the carry into it falls out directly
   assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle adder/subtractor processing CHUNK bits per clock
module chunked_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   chunked_serial_adder_if.slave  bus
);

   localparam int             NCHUNK   = WIDTH / CHUNK;
   localparam int             IW       = idx_bits(NCHUNK);
   localparam logic [IW-1:0]  LAST_IDX = IW'(NCHUNK - 1);

   if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("chunked_serial_adder: CHUNK must divide WIDTH");
   end

   state_t           state;
   logic [IW-1:0]    idx;
   logic             carry;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum_q;
   logic             c_out_q;
   logic             ovf_q;
   logic             out_valid_q;
   logic             in_ready_q;
   logic             busy_q;

   logic [CHUNK-1:0] ch_a;
   logic [CHUNK-1:0] ch_b;
   logic [CHUNK-1:0] ch_sum;
   logic             ch_cout;
   logic             ch_cmsb;

   // Select the chunk currently being added from the captured operands
   assign ch_a = op_a[idx*CHUNK +: CHUNK];
   assign ch_b = op_b[idx*CHUNK +: CHUNK];

   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk_adder (
      .a     (ch_a),
      .b     (ch_b),
      .c_in  (carry),
      .sum   (ch_sum),
      .c_out (ch_cout),
      .c_msb (ch_cmsb)
   );

   // Control FSM plus operand and result registers; all outputs are registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         carry       <= 1'b0;
         op_a        <= '0;
         op_b        <= '0;
         sum_q       <= '0;
         c_out_q     <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  // Subtraction is a + ~b + 1; c_in plays no part then
                  op_a        <= bus.a;
                  op_b        <= bus.sub ? ~bus.b : bus.b;
                  carry       <= bus.sub ? 1'b1 : bus.c_in;
                  idx         <= '0;
                  in_ready_q  <= 1'b0;
                  busy_q      <= 1'b1;
                  state       <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum_q[idx*CHUNK +: CHUNK] <= ch_sum;
               carry                     <= ch_cout;
               if (idx == LAST_IDX) begin
                  // idx parks on the last chunk; it is cleared at the next capture
                  c_out_q     <= ch_cout;
                  ovf_q       <= ch_cmsb ^ ch_cout;
                  out_valid_q <= 1'b1;
                  state       <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.c_out     = c_out_q;
   assign bus.ovf       = ovf_q;
   assign bus.busy      = busy_q;

endmodule

// File: doc/chunked_serial_adder.md
CHUNKED_SERIAL_ADDER -- requirements
Module: chunked_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; SHALL be ≥ 1.
REQ-002 Parameter CHUNK, default 4: bits added per cycle; SHALL divide WIDTH exactly; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set a/b/c_in/sub is presented.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 c_in  input  1  carry-in, used in add mode only.
REQ-010 sub  input  1  0 = a+b+c_in; 1 = a−b (two's complement).
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 c_out  output  1  carry out of the MSB; in sub mode, 1 means no borrow.
REQ-015 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-016 busy  output  1  high in RUN and DONE.

Function
REQ-017 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-018 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready at an edge:
- capture a, (sub ? ~b : b);
- set carry register to (sub ? 1 : c_in), ignoring c_in when sub=1;
- clear chunk index to 0;
- go to RUN.
REQ-019 RUN: each cycle adds chunk[idx] of the captured operands plus the carry register, writes the CHUNK result bits into sum[idx*CHUNK +: CHUNK], updates the carry register, and increments idx.
REQ-020 On the edge that processes idx = NCHUNK−1, SHALL:
- load c_out with the final carry;
- load ovf from the carry into and out of bit WIDTH−1;
- go to DONE.
REQ-021 Latency: out_valid SHALL rise exactly NCHUNK cycles after the acceptance edge; with CHUNK=WIDTH this is 1 cycle.
REQ-022 DONE: out_valid=1; sum/c_out/ovf SHALL be stable until out_valid&&out_ready, then go to IDLE at that edge.
REQ-023 in_ready SHALL be 0 in RUN and DONE; a new operand is accepted no earlier than the cycle after the result handshake, so there is no overlap.
REQ-024 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-025 After the result handshake, sum/c_out/ovf SHALL retain their last values until the next RUN overwrites them chunk by chunk.
REQ-026 Captured operands SHALL NOT change during RUN, regardless of changes on a, b, c_in or sub.
REQ-027 Idx SHALL be ceil(log2(NCHUNK)) bits wide, minimum 1, and never exceed NCHUNK−1.

Reset
REQ-028 rst_n low SHALL asynchronously force:
- state=IDLE, idx=0, carry register=0;
- captured operands=0;
- sum=0, c_out=0, ovf=0, out_valid=0, busy=0.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation with no result; after release, in_ready=1 in the first cycle.

Structure
REQ-030 A shared package adder_pkg SHALL hold the FSM state encodings (2-bit localparams IDLE/RUN/DONE).
REQ-031 The per-cycle CHUNK-bit adder SHALL be a combinational sub-module, chunk_adder, parametrised by CHUNK. It has inputs a, b and c_in, and outputs sum, c_out and c_msb (carry into its top bit).
REQ-032 The top module SHALL contain only the FSM, operand and result registers, and the chunk multiplexing.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-033 0xFFFF + 0x0001, c_in=0, sub=0 -> after 4 cycles out_valid=1, sum=0x0000, c_out=1, ovf=0.
REQ-034 0x7FFF + 0x0001, sub=0 -> sum=0x8000, c_out=0, ovf=1; then 0x0005 − 0x0007, sub=1, c_in=1 (ignored) -> sum=0xFFFE, c_out=0, ovf=0.
REQ-035 Back-pressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and changing a/b -> out_valid stays 1, sum/c_out/ovf unchanged, in_ready=0, no capture; then out_ready=1 -> IDLE next cycle.
REQ-036 Reset: pulse rst_n low asynchronously mid-RUN (idx=2) -> all outputs 0 immediately; in_ready=1 after release; no out_valid appears.
REQ-037 Parameter sweep: CHUNK ∈ {1, 4, 16} with 1000 random (a, b, c_in, sub) each, compared against a behavioural model. Latency must equal NCHUNK; sum, c_out and ovf must match exactly.
